// File: rtl/noc_inject_ni_pkg.sv
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared types and head-flit field offsets for the NoC
//                injection network interface.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    typedef enum logic [1:0] {
        FT_NONE = 2'd0,
        FT_HEAD = 2'd1,
        FT_BODY = 2'd2,
        FT_TAIL = 2'd3
    } flit_type_e;

    typedef enum logic [0:0] {
        NI_IDLE = 1'b0,
        NI_BODY = 1'b1
    } ni_state_e;

    // Head flit layout: {.., len, src, dest} packed from bit 0 upwards.
    function automatic int head_src_lo(input int dest_w);
        return dest_w;
    endfunction

    function automatic int head_len_lo(input int dest_w);
        return 2 * dest_w;
    endfunction

    function automatic int head_min_width(input int dest_w, input int len_w);
        return 2 * dest_w + len_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_inject_ni_if.sv
// ============================================================================
//  Module      : noc_inject_ni_if
//  Description : Host-side header/payload handshakes, router-side flit and
//                credit signals, and sticky error flags of the injection NI.
//                slave  : used by the NI itself
//                master : used by the host / router model driving the NI
//                Optional macro NOC_NI_PARITY_EN adds flit_parity.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface noc_inject_ni_if #(
    parameter int DATA_W  = 32,
    parameter int DEST_W  = 4,
    parameter int MAX_LEN = 8,
    parameter int CREDITS = 4
);
    import noc_pkg::*;

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_W = $clog2(CREDITS + 1);

    logic              hdr_valid;
    logic              hdr_ready;
    logic [DEST_W-1:0] hdr_dest;
    logic [LEN_W-1:0]  hdr_len;
    logic              data_valid;
    logic              data_ready;
    logic [DATA_W-1:0] data;
    logic              flit_valid;
    flit_type_e        flit_type;
    logic [DATA_W-1:0] flit_data;
    logic              credit_in;
    logic [CNT_W-1:0]  credit_cnt;
    logic              err_len;
    logic              err_credit;
`ifdef NOC_NI_PARITY_EN
    logic              flit_parity;

    modport slave (
        input  hdr_valid, hdr_dest, hdr_len, data_valid, data, credit_in,
        output hdr_ready, data_ready, flit_valid, flit_type, flit_data,
               credit_cnt, err_len, err_credit, flit_parity
    );
    modport master (
        output hdr_valid, hdr_dest, hdr_len, data_valid, data, credit_in,
        input  hdr_ready, data_ready, flit_valid, flit_type, flit_data,
               credit_cnt, err_len, err_credit, flit_parity
    );
`else
    modport slave (
        input  hdr_valid, hdr_dest, hdr_len, data_valid, data, credit_in,
        output hdr_ready, data_ready, flit_valid, flit_type, flit_data,
               credit_cnt, err_len, err_credit
    );
    modport master (
        output hdr_valid, hdr_dest, hdr_len, data_valid, data, credit_in,
        input  hdr_ready, data_ready, flit_valid, flit_type, flit_data,
               credit_cnt, err_len, err_credit
    );
`endif

endinterface

`default_nettype wire

// File: rtl/noc_inject_ni_credit.sv
// ============================================================================
//  Module      : noc_credit_counter
//  Description : Saturating up/down credit counter with sticky overflow flag.
//  Ports       : clk, rst_n (async active-low)
//                inc  - credit returned by router
//                dec  - flit launched (never asserted at zero count)
//                cnt  - current credit count, resets to CREDITS
//                err  - sticky: inc seen while already at CREDITS
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module noc_credit_counter #(
    parameter int CREDITS = 4,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    input  wire logic             dec,
    output logic      [CNT_W-1:0] cnt,
    output logic                  err
);

    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_full;

    assign w_full = (r_cnt == c_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= c_FULL;
            r_err <= 1'b0;
        end else begin
            // The error is flagged even when a launch cancels the increment.
            if (inc && w_full) begin
                r_err <= 1'b1;
            end
            case ({inc, dec})
                2'b10:   if (!w_full)       r_cnt <= r_cnt + c_ONE;
                2'b01:   if (r_cnt != '0)   r_cnt <= r_cnt - c_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign cnt = r_cnt;
    assign err = r_err;

endmodule

`default_nettype wire

// File: rtl/noc_inject_ni.sv
// ============================================================================
//  Module      : noc_inject_ni
//  Description : NoC injection network interface. Turns a header plus a
//                stream of payload words into HEAD/BODY/TAIL flits for the
//                router local port, gated by credit-based flow control.
//  Ports       : clk, rst_n (async active-low)
//                bus (noc_inject_ni_if.slave): header and payload
//                handshakes, registered flit outputs, credit return and
//                count, sticky err_len / err_credit.
//  Options     : NOC_NI_PARITY_EN adds registered even parity flit_parity.
//  Note        : parameters must match those of the connected interface.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module noc_inject_ni
    import noc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEST_W  = 4,
    parameter int SRC_ID  = 0,
    parameter int MAX_LEN = 8,
    parameter int CREDITS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    noc_inject_ni_if.slave     bus
);

    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int CNT_W    = $clog2(CREDITS + 1);
    localparam int c_SRC_LO = head_src_lo(DEST_W);
    localparam int c_LEN_LO = head_len_lo(DEST_W);
    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_ONE     = LEN_W'(1);

    generate
        if (DATA_W < head_min_width(DEST_W, LEN_W)) begin : g_width_check
            $fatal(1, "noc_inject_ni: DATA_W too small for head flit fields");
        end
    endgenerate

    ni_state_e         r_state, w_state_nxt;
    logic [LEN_W-1:0]  r_rem, w_rem_nxt;
    logic              r_flit_valid, w_flit_valid_nxt;
    flit_type_e        r_flit_type, w_flit_type_nxt;
    logic [DATA_W-1:0] r_flit_data, w_flit_data_nxt;
    logic              r_err_len, w_err_len_nxt;
    logic              w_hdr_ready, w_data_ready, w_launch;
    logic              w_has_credit, w_len_ok, w_err_credit;
    logic [CNT_W-1:0]  w_credit_cnt;
    logic [DATA_W-1:0] w_head;

    assign w_has_credit = (w_credit_cnt != '0);
    assign w_len_ok     = (bus.hdr_len != '0) && (bus.hdr_len <= c_MAX_LEN);

    always_comb begin
        w_head = '0;
        w_head[DEST_W-1:0]           = bus.hdr_dest;
        w_head[c_SRC_LO +: DEST_W]   = DEST_W'(SRC_ID);
        w_head[c_LEN_LO +: LEN_W]    = bus.hdr_len;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_rem_nxt        = r_rem;
        w_flit_valid_nxt = 1'b0;
        w_flit_type_nxt  = FT_NONE;
        w_flit_data_nxt  = '0;
        w_err_len_nxt    = r_err_len;
        w_hdr_ready      = 1'b0;
        w_data_ready     = 1'b0;
        w_launch         = 1'b0;
        case (r_state)
            NI_IDLE: begin
                w_hdr_ready = w_has_credit;
                if (bus.hdr_valid && w_has_credit) begin
                    if (w_len_ok) begin
                        w_launch         = 1'b1;
                        w_flit_valid_nxt = 1'b1;
                        w_flit_type_nxt  = FT_HEAD;
                        w_flit_data_nxt  = w_head;
                        w_rem_nxt        = bus.hdr_len;
                        w_state_nxt      = NI_BODY;
                    end else begin
                        // Bad length: swallow the header, no flit, no credit.
                        w_err_len_nxt = 1'b1;
                    end
                end
            end
            NI_BODY: begin
                w_data_ready = w_has_credit;
                if (bus.data_valid && w_has_credit) begin
                    w_launch         = 1'b1;
                    w_flit_valid_nxt = 1'b1;
                    w_flit_data_nxt  = bus.data;
                    w_rem_nxt        = r_rem - c_ONE;
                    if (r_rem == c_ONE) begin
                        w_flit_type_nxt = FT_TAIL;
                        w_state_nxt     = NI_IDLE;
                    end else begin
                        w_flit_type_nxt = FT_BODY;
                    end
                end
            end
            default: w_state_nxt = NI_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= NI_IDLE;
            r_rem        <= '0;
            r_flit_valid <= 1'b0;
            r_flit_type  <= FT_NONE;
            r_flit_data  <= '0;
            r_err_len    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rem        <= w_rem_nxt;
            r_flit_valid <= w_flit_valid_nxt;
            r_flit_type  <= w_flit_type_nxt;
            r_flit_data  <= w_flit_data_nxt;
            r_err_len    <= w_err_len_nxt;
        end
    end

    noc_credit_counter #(
        .CREDITS (CREDITS),
        .CNT_W   (CNT_W)
    ) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.credit_in),
        .dec   (w_launch),
        .cnt   (w_credit_cnt),
        .err   (w_err_credit)
    );

`ifdef NOC_NI_PARITY_EN
    logic r_flit_parity;

    // Idle cycles carry FT_NONE and zero data, so parity is 0 there too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit_parity <= 1'b0;
        end else begin
            r_flit_parity <= ^{w_flit_type_nxt, w_flit_data_nxt};
        end
    end

    assign bus.flit_parity = r_flit_parity;
`endif

    assign bus.hdr_ready  = w_hdr_ready;
    assign bus.data_ready = w_data_ready;
    assign bus.flit_valid = r_flit_valid;
    assign bus.flit_type  = r_flit_type;
    assign bus.flit_data  = r_flit_data;
    assign bus.credit_cnt = w_credit_cnt;
    assign bus.err_len    = r_err_len;
    assign bus.err_credit = w_err_credit;

endmodule

`default_nettype wire
